// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input
// and the decode-side valid/ready instruction handoff.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instruction,
    output instr_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instruction,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem read,
// hands instructions to decode, squashes fetches on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic [31:0] rd_pc;

  assign rd_pc = bus.redirect_pc & ~32'h3;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid;
  assign bus.instruction = instr;
  assign bus.instr_pc    = ipc;

  // Fetch FSM; redirect overrides everything except IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      req   <= 1'b0;
      valid <= 1'b0;
      instr <= NOP_INSTR;
      ipc   <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (bus.redirect_valid) begin
            pc    <= rd_pc;
            valid <= 1'b0;
            instr <= NOP_INSTR;
            if (bus.imem_gnt) begin
              state <= DROP;
              req   <= 1'b0;
            end else begin
              state <= REQ;
              req   <= 1'b1;
            end
          end else if (bus.imem_gnt) begin
            state <= WAIT;
            req   <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.redirect_valid) begin
            pc    <= rd_pc;
            valid <= 1'b0;
            instr <= NOP_INSTR;
            if (bus.imem_rvalid) begin
              state <= REQ;
              req   <= 1'b1;
            end else begin
              state <= DROP;
            end
          end else if (bus.imem_rvalid) begin
            instr <= bus.imem_rdata;
            ipc   <= pc;
            valid <= 1'b1;
            pc    <= pc + 32'd4;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.redirect_valid) begin
            pc    <= rd_pc;
            valid <= 1'b0;
            instr <= NOP_INSTR;
            state <= REQ;
            req   <= 1'b1;
          end else if (bus.instr_ready) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            state <= REQ;
            req   <= 1'b1;
          end
        end
        DROP: begin
          if (bus.redirect_valid) begin
            pc    <= rd_pc;
            valid <= 1'b0;
            instr <= NOP_INSTR;
          end
          if (bus.imem_rvalid) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-driven imem handshake,
// back-pressure, redirects, PC wrap and async reset.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'h0, bus.imem_req}, 32'h0);
    chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_vld"}, {31'h0, bus.instr_valid}, 32'h0);
    chk({tag, "_ins"}, bus.instruction, 32'h13);
    chk({tag, "_ipc"}, bus.instr_pc, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_in();
    bus.instr_ready = 1'b0;
    step();
    step();
    chk_reset("rst");
    rst = 1'b0;

    // first fetch at 0x0
    step();
    chk("f0_req", {31'h0, bus.imem_req}, 32'h1);
    chk("f0_addr", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    step();
    chk("f0_wait_req", {31'h0, bus.imem_req}, 32'h0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    step();
    chk("f0_vld", {31'h0, bus.instr_valid}, 32'h1);
    chk("f0_ins", bus.instruction, 32'h0050_0093);
    chk("f0_ipc", bus.instr_pc, 32'h0);
    chk("f0_pc", bus.imem_addr, 32'h4);
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b1;

    // second fetch at 0x4, 3 cycles after the first request
    step();
    chk("f1_vld", {31'h0, bus.instr_valid}, 32'h0);
    chk("f1_nop", bus.instruction, 32'h13);
    chk("f1_req", {31'h0, bus.imem_req}, 32'h1);
    chk("f1_addr", bus.imem_addr, 32'h4);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0010_8113;
    bus.instr_ready = 1'b0;
    step();
    chk("f1_vld2", {31'h0, bus.instr_valid}, 32'h1);
    chk("f1_ins", bus.instruction, 32'h0010_8113);
    chk("f1_ipc", bus.instr_pc, 32'h4);
    bus.imem_rvalid = 1'b0;

    // decode back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_vld", {31'h0, bus.instr_valid}, 32'h1);
      chk("bp_ins", bus.instruction, 32'h0010_8113);
      chk("bp_ipc", bus.instr_pc, 32'h4);
      chk("bp_req", {31'h0, bus.imem_req}, 32'h0);
    end
    bus.instr_ready = 1'b1;
    step();
    chk("bp_rel_req", {31'h0, bus.imem_req}, 32'h1);
    chk("bp_rel_addr", bus.imem_addr, 32'h8);

    // grant withheld for 4 cycles
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ng_req", {31'h0, bus.imem_req}, 32'h1);
      chk("ng_addr", bus.imem_addr, 32'h8);
      chk("ng_vld", {31'h0, bus.instr_valid}, 32'h0);
    end
    bus.imem_gnt = 1'b1;
    step();

    // redirect in WAIT, second redirect while in DROP
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    step();
    chk("rw_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rw_addr", bus.imem_addr, 32'h100);
    chk("rw_vld", {31'h0, bus.instr_valid}, 32'h0);
    bus.redirect_pc = 32'h0000_0302;
    step();
    chk("rd_addr", bus.imem_addr, 32'h300);
    chk("rd_req", {31'h0, bus.imem_req}, 32'h0);
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    step();
    chk("rd_vld", {31'h0, bus.instr_valid}, 32'h0);
    chk("rd_ins", bus.instruction, 32'h13);
    chk("rd_req2", {31'h0, bus.imem_req}, 32'h1);
    chk("rd_addr2", bus.imem_addr, 32'h300);
    bus.imem_rvalid = 1'b0;

    // redirect coinciding with rvalid: no DROP
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b1;
    bus.imem_rdata     = 32'hCAFE_F00D;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    step();
    chk("rv_req", {31'h0, bus.imem_req}, 32'h1);
    chk("rv_addr", bus.imem_addr, 32'h200);
    chk("rv_vld", {31'h0, bus.instr_valid}, 32'h0);

    // redirect in REQ to the top word, then wrap
    bus.imem_rvalid = 1'b0;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wr_req", {31'h0, bus.imem_req}, 32'h1);
    bus.redirect_valid = 1'b0;
    bus.imem_gnt       = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1234_5678;
    step();
    chk("wr_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wr_ins", bus.instruction, 32'h1234_5678);
    chk("wr_pc", bus.imem_addr, 32'h0);
    bus.imem_rvalid = 1'b0;
    step();
    chk("wr_req2", {31'h0, bus.imem_req}, 32'h1);
    chk("wr_addr2", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;

    // asynchronous reset while in WAIT
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    step();
    chk_reset("arst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
